mul4_tournament_scheduler: RTL

Sequences fitness evaluation of a population of evolved 2×2-bit multiplier candidates (bit-sliced, 16 lanes per 16-bit vector) that share one evaluation port. Selects one candidate at a time through an external mux, drives the exhaustive stimulus vectors and waits for settling. Scores the candidate's four output vectors against the golden product and reports per-candidate scores plus the tournament winner. Sits between the population mux and the selection logic of the GE experiment harness.

---
 rtl/mul4_eval_pkg.sv | 37 +++
 rtl/mul4_lane_scorer.sv | 10 +
 rtl/mul4_tournament_scheduler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mul4_eval_pkg.sv
// Shared constants and types for fitness evaluation of bit-sliced 2x2 multiplier candidates.
// Each 16-bit vector carries one lane per input combination: lane L has a = L[3:2], b = L[1:0].
package mul4_eval_pkg;

  localparam int SCORE_W = 7;

  localparam logic [15:0] STIM_A1 = 16'hFF00;
  localparam logic [15:0] STIM_A0 = 16'hF0F0;
  localparam logic [15:0] STIM_B1 = 16'hCCCC;
  localparam logic [15:0] STIM_B0 = 16'hAAAA;

  localparam logic [15:0] GOLD_Y3 = 16'h8000;
  localparam logic [15:0] GOLD_Y2 = 16'h4C00;
  localparam logic [15:0] GOLD_Y1 = 16'h6AC0;
  localparam logic [15:0] GOLD_Y0 = 16'hA0A0;

  localparam logic [SCORE_W-1:0] PERFECT_SCORE = 7'd64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SETTLE,
    S_SCORE,
    S_REPORT,
    S_DONE
  } state_t;

  function automatic logic [15:0] golden(input logic [1:0] k);
    case (k)
      2'd0:    golden = GOLD_Y0;
      2'd1:    golden = GOLD_Y1;
      2'd2:    golden = GOLD_Y2;
      default: golden = GOLD_Y3;
    endcase
  endfunction

endpackage

// File: rtl/mul4_lane_scorer.sv
// Counts lanes where a candidate output vector agrees with the golden vector (0..16).
module mul4_lane_scorer (
  input  logic [15:0] y,
  input  logic [15:0] g,
  output logic [4:0]  count
);

  assign count = 5'($countones(~(y ^ g)));

endmodule

// File: rtl/mul4_tournament_scheduler.sv
// Walks the latched candidate mask, drives exhaustive stimulus to each selected candidate,
// scores its four output vectors one per cycle and tracks the best (lowest index on ties).
module mul4_tournament_scheduler
  import mul4_eval_pkg::*;
#(
  parameter int N_CAND     = 8,
  parameter int SETTLE     = 1,
  parameter bit EARLY_EXIT = 1'b1,
  localparam int IDX_W     = $clog2(N_CAND)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_CAND-1:0]  cand_mask,
  output logic               busy,
  output logic [IDX_W-1:0]   cand_sel,
  output logic [15:0]        a1,
  output logic [15:0]        a0,
  output logic [15:0]        b1,
  output logic [15:0]        b0,
  input  logic [15:0]        y3,
  input  logic [15:0]        y2,
  input  logic [15:0]        y1,
  input  logic [15:0]        y0,
  output logic               score_valid,
  output logic [IDX_W-1:0]   score_idx,
  output logic [SCORE_W-1:0] score_value,
  output logic               done,
  output logic               best_valid,
  output logic [IDX_W-1:0]   best_idx,
  output logic [SCORE_W-1:0] best_score
);

  state_t               state, state_nx;
  logic [N_CAND-1:0]    mask_q;
  logic [IDX_W-1:0]     cur_idx;
  logic [IDX_W-1:0]     first_idx;
  logic [IDX_W-1:0]     next_idx;
  logic                 has_next;
  logic [3:0]           settle_cnt;
  logic [1:0]           k;
  logic [SCORE_W-1:0]   acc;
  logic [15:0]          y_k;
  logic [4:0]           lane_count;

  // Lowest set bit of the incoming mask, and the next set bit above the current candidate.
  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    first_idx = '0;
    for (int i = N_CAND - 1; i >= 0; i--) begin
      if (cand_mask[i]) first_idx = IDX_W'(i);
    end
  end

  always_comb begin
    has_next = 1'b0;
    next_idx = '0;
    for (int i = N_CAND - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(cur_idx))) begin
        has_next = 1'b1;
        next_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    case (k)
      2'd0:    y_k = y0;
      2'd1:    y_k = y1;
      2'd2:    y_k = y2;
      default: y_k = y3;
    endcase
  end

  mul4_lane_scorer u_scorer (
    .y     (y_k),
    .g     (golden(k)),
    .count (lane_count)
  );

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // An empty mask still passes through SELECT, which sends it straight to DONE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_SELECT;
      S_SELECT: begin
        if (mask_q == '0)     state_nx = S_DONE;
        else if (SETTLE == 0) state_nx = S_SCORE;
        else                  state_nx = S_SETTLE;
      end
      S_SETTLE: if (settle_cnt <= 4'd1) state_nx = S_SCORE;
      S_SCORE:  if (k == 2'd3) state_nx = S_REPORT;
      S_REPORT: begin
        if (EARLY_EXIT && (acc == PERFECT_SCORE)) state_nx = S_DONE;
        else if (has_next)                        state_nx = S_SELECT;
        else                                      state_nx = S_DONE;
      end
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // NOTE: every datapath register is reset so an aborted tournament leaves no stale outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q     <= '0;
      cur_idx    <= '0;
      settle_cnt <= '0;
      k          <= '0;
      acc        <= '0;
      best_valid <= 1'b0;
      best_idx   <= '0;
      best_score <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mask_q     <= cand_mask;
            cur_idx    <= first_idx;
            best_valid <= 1'b0;
            best_idx   <= '0;
            best_score <= '0;
          end
        end
        S_SELECT: begin
          settle_cnt <= 4'(SETTLE);
          k          <= '0;
          acc        <= '0;
        end
        S_SETTLE: settle_cnt <= settle_cnt - 4'd1;
        S_SCORE: begin
          acc <= acc + {2'b00, lane_count};
          k   <= k + 2'd1;
        end
        S_REPORT: begin
          if (!best_valid || (acc > best_score)) begin
            best_valid <= 1'b1;
            best_idx   <= cur_idx;
            best_score <= acc;
          end
          if (has_next) cur_idx <= next_idx;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign score_valid = (state == S_REPORT);
  assign score_idx   = score_valid ? cur_idx : '0;
  assign score_value = score_valid ? acc : '0;
  assign cand_sel    = cur_idx;

  assign a1 = busy ? STIM_A1 : '0;
  assign a0 = busy ? STIM_A0 : '0;
  assign b1 = busy ? STIM_B1 : '0;
  assign b0 = busy ? STIM_B0 : '0;

endmodule
